// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch/branch-prediction slice.
//   ctr_e       : 2-bit saturating direction counter encodings
//   btb_entry_t : one branch-target-buffer record
//   PC_INC      : sequential fetch increment
//   ctr_next()  : saturating counter update
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_e;

   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      ctr_e        ctr;
   } btb_entry_t;

   localparam logic [31:0] PC_INC = 32'd4;

   // Saturating increment on taken, saturating decrement on not-taken.
   function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
      case (c)
         SNT:     return taken ? WNT : SNT;
         WNT:     return taken ? WT  : SNT;
         WT:      return taken ? ST  : WNT;
         ST:      return taken ? ST  : WT;
         default: return SNT;
      endcase
   endfunction

endpackage

// File: rtl/btb_table.sv
// ---------------------------------------------------------------------------
// btb_table
// Fully associative branch target buffer with round-robin replacement.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   lookup_tag[29:0]       : word address being fetched
//   hit, hit_ctr, hit_target : combinational lookup result (pre-update state)
//   upd_en, upd_tag, upd_target, upd_taken : resolved branch/jump update
// Parameter ENTRIES must be a power of two (2..16) so the pointer wraps
// naturally at its width.
// ---------------------------------------------------------------------------
module btb_table
   import fetch_pkg::*;
#(
   parameter int ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] lookup_tag,
   output logic        hit,
   output ctr_e        hit_ctr,
   output logic [31:0] hit_target,
   input  logic        upd_en,
   input  logic [29:0] upd_tag,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);

   localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   btb_entry_t       btb_q [ENTRIES];
   logic [PTR_W-1:0] rr_ptr_q;
   logic             upd_hit;
   logic [PTR_W-1:0] upd_idx;

   // Fetch-side match. Tags are unique (allocation only happens on a miss),
   // so the lowest-index priority is only a tie-break formality.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
      hit        = 1'b0;
      hit_ctr    = SNT;
      hit_target = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (btb_q[i].valid && (btb_q[i].tag == lookup_tag)) begin
            hit        = 1'b1;
            hit_ctr    = btb_q[i].ctr;
            hit_target = btb_q[i].target;
         end
      end
   end

   // Update-side match, independent of the fetch-side lookup.
   always_comb begin
      upd_hit = 1'b0;
      upd_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (btb_q[i].valid && (btb_q[i].tag == upd_tag)) begin
            upd_hit = 1'b1;
            upd_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         // NOTE: only valid and ctr are reset; tag/target are don't-care while valid is low, so they stay plain storage.
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i].valid <= 1'b0;
            btb_q[i].ctr   <= SNT;
         end
      end else if (upd_en) begin
         if (upd_hit) begin
            btb_q[upd_idx].ctr <= ctr_next(btb_q[upd_idx].ctr, upd_taken);
            if (upd_taken) begin
               btb_q[upd_idx].target <= upd_target;
            end
         end else if (upd_taken) begin
            btb_q[rr_ptr_q] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: WT};
            rr_ptr_q        <= rr_ptr_q + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_predict.sv
// ---------------------------------------------------------------------------
// fetch_predict
// Fetch PC register with BTB-based next-PC prediction.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   stall             : hold the PC
//   redirect, redirect_pc : execute-stage mispredict correction (wins over stall)
//   upd_en, upd_pc, upd_target, upd_taken : resolved branch/jump training
//   pc                : current fetch PC
//   pred_taken, pred_target : prediction for pc (pred_target = pc+4 if not taken)
// Optional macro FETCH_PREDICT_PERF_EN adds lookup_cnt / hit_cnt counters.
// ---------------------------------------------------------------------------
module fetch_predict
   import fetch_pkg::*;
#(
   parameter int          ENTRIES  = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output logic [31:0] pc,
   output logic        pred_taken,
   output logic [31:0] pred_target
`ifdef FETCH_PREDICT_PERF_EN
   ,
   output logic [31:0] lookup_cnt,
   output logic [31:0] hit_cnt
`endif
);

   logic        hit;
   ctr_e        hit_ctr;
   logic [31:0] hit_target;
   logic        unused_upd_lsb;

   // Instructions are word aligned; the low PC bits never reach the tag.
   assign unused_upd_lsb = ^upd_pc[1:0];

   btb_table #(
      .ENTRIES (ENTRIES)
   ) u_btb (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_tag (pc[31:2]),
      .hit        (hit),
      .hit_ctr    (hit_ctr),
      .hit_target (hit_target),
      .upd_en     (upd_en),
      .upd_tag    (upd_pc[31:2]),
      .upd_target (upd_target),
      .upd_taken  (upd_taken)
   );

   // Prediction is forced to the post-reset sequential value while rst_n is
   // low, so downstream never sees an X-derived prediction.
   always_comb begin
      pred_taken  = 1'b0;
      pred_target = RESET_PC + PC_INC;
      if (rst_n) begin
         pred_taken  = hit && (hit_ctr >= WT);
         pred_target = pred_taken ? hit_target : (pc + PC_INC);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (!stall) begin
         pc <= pred_target;
      end
   end

`ifdef FETCH_PREDICT_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lookup_cnt <= '0;
         hit_cnt    <= '0;
      end else if (!stall && !redirect) begin
         lookup_cnt <= lookup_cnt + 32'd1;
         if (hit) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
- REQ-001 Parameter ENTRIES, default 8: number of fully associative branch-target-buffer (BTB) entries; SHALL be a power of two, from 2 to 16.
- REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
- REQ-003 One clock. Reset is synchronous and active-low.
- REQ-004 Port clk, input, 1: rising-edge clock.
- REQ-005 Port rst_n, input, 1: synchronous active-low reset.
- REQ-006 Port stall, input, 1: hold the PC (hazard stall).
- REQ-007 Port redirect, input, 1: execute-stage mispredict (BandJ).
- REQ-008 Port redirect_pc, input, 32: corrected next PC (PC_out of the execute stage).
- REQ-009 Port upd_en, input, 1: a branch or jump has resolved this cycle (B|J).
- REQ-010 Port upd_pc, input, 32: PC of the resolved instruction.
- REQ-011 Port upd_target, input, 32: branch/jump target.
- REQ-012 Port upd_taken, input, 1: resolved outcome (J|BS).
- REQ-013 Port pc, output, 32: current fetch PC.
- REQ-014 Port pred_taken, output, 1: prediction for pc; carried down the pipeline as prediect_bs.
- REQ-015 Port pred_target, output, 32: predicted next PC.

Function
- REQ-016 Lookup SHALL be combinational on pc: hit = some valid entry has tag == pc[31:2].
- REQ-017 pred_taken SHALL be 1 only when there is a hit and that entry's counter >= 2'b10.
- REQ-018 pred_target SHALL be the hit entry's target when pred_taken = 1; otherwise it SHALL be pc+4.
- REQ-019 The next-PC priority SHALL be: redirect (pc <= redirect_pc) > stall (hold) > pc <= pred_target. Latency is 1 cycle.
- REQ-020 Update on a hit: the counter SHALL saturate-increment if upd_taken, else saturate-decrement; the target SHALL be overwritten with upd_target when upd_taken.
- REQ-021 Counter saturation: a counter at 3 SHALL stay 3 on taken; a counter at 0 SHALL stay 0 on not-taken.
- REQ-022 Update on a miss with upd_taken = 1: the entry at the round-robin pointer SHALL be written (valid = 1, tag, target, counter = 2'b10). The pointer SHALL then advance, wrapping from ENTRIES-1 to 0.
- REQ-023 Update on a miss with upd_taken = 0: there SHALL be no allocation and no pointer change.
- REQ-024 Lookup and update in the same cycle SHALL use pre-update state; the update is visible the next cycle.
- REQ-025 Redirect SHALL override stall in the same cycle. The update is applied regardless of stall.
- REQ-026 Table writes SHALL occur only on the clk edge, with at most one entry written per cycle.

Reset
- REQ-027 When rst_n = 0 at a clk edge: pc = RESET_PC, all valid bits = 0, round-robin pointer = 0, counters = 2'b00.
- REQ-028 While in reset, pred_taken SHALL be 0 and pred_target SHALL be RESET_PC+4.
- REQ-029 Reset SHALL override redirect, stall and update.

Configuration
- REQ-030 Macro FETCH_PREDICT_PERF_EN.
- REQ-031 When defined, the block SHALL add output ports lookup_cnt[31:0] and hit_cnt[31:0].
  - lookup_cnt counts cycles with stall = 0 and redirect = 0.
  - hit_cnt counts those cycles in which the lookup also hit.
  - Both are cleared by reset and wrap at 2^32.
- REQ-032 When undefined, those ports and registers SHALL be absent, with no other behaviour change.

Structure
- REQ-033 Shared package fetch_pkg SHALL hold:
  - counter encodings SNT = 0, WNT = 1, WT = 2, ST = 3;
  - the entry record (valid, tag[29:0], target[31:0], ctr[1:0]);
  - the PC increment constant 4.
- REQ-034 The storage, match, update and round-robin logic SHALL live in one sub-module, btb_table; PC register and next-PC selection SHALL stay in fetch_predict.

Verification
- REQ-035 Reset test: after rst_n low then high, pc = 0, then 4, then 8 with no hits; pred_taken = 0.
- REQ-036 Allocation test: upd_en = 1, upd_pc = 0x10, upd_target = 0x40, upd_taken = 1.
  - When pc later reaches 0x10, pred_taken = 1 and the next pc = 0x40.
- REQ-037 Counter test: train 0x10 taken three times, then not-taken twice.
  - Result: ctr = 3 then 1; pc 0x10 predicts not-taken with next pc = 0x14.
- REQ-038 Redirect test: redirect = 1, redirect_pc = 0x200 together with stall = 1.
  - Next pc = 0x200.
  - Stall alone holds pc for N cycles.
- REQ-039 Replacement test: allocate ENTRIES+1 distinct taken PCs.
  - The first PC misses, the pointer wraps to 1, and the other entries still hit.
- REQ-040 Same-cycle test: update to the current pc in the same cycle as its lookup.
  - This cycle's prediction uses the old state; the new state is seen the next time that pc is fetched.
